// File: rtl/iomem_pixel_fifo.sv
// iomem_pixel_fifo
// Memory-mapped pixel FIFO on the picosoc iomem bus. Stream words arrive on
// pix_valid/pix_ready/pix_data and are drained by firmware reading DATA.
//
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   iomem_valid/ready      - bus request / one-cycle completion pulse
//   iomem_wstrb            - byte write enables (0 = read)
//   iomem_addr/wdata/rdata - byte address, write data, read data
//   pix_valid/ready/data   - pixel stream input
//   irq                    - level interrupt when count >= thresh
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 CTRL   : bit0 en, bit1 irq_en, [15:8] thresh
//   0x4 STATUS : bit0 empty, bit1 full, bit2 ovf (W1C), bit3 udf (W1C), [15:8] count
//   0x8 DATA   : read pops head word (0 and udf when empty)
//   0xC reserved
//
// Build option: IOMEM_PIXEL_FIFO_IRQ_EN enables irq_en/thresh/irq; when it is
// undefined irq is tied low and CTRL[15:1] are read-as-zero.
module iomem_pixel_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          en, irq_en, ovf, udf;
  logic [7:0]    thresh;
  logic [7:0]    count_field;

  logic          hit, access, is_write;
  logic          push, pop, empty, full;
  logic          ctrl_wr, status_clr_ovf, status_clr_udf, udf_set, ovf_set;
  reg_sel_e      reg_sel;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, iomem_wstrb};

  assign hit      = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  // Only the first cycle of a held request commits; the ready cycle is idle.
  assign access   = hit && !iomem_ready;
  assign is_write = |iomem_wstrb;
  assign reg_sel  = reg_sel_e'(iomem_addr[3:2]);

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pix_ready = en && !full;
  assign push      = pix_valid && pix_ready;
  assign ovf_set   = pix_valid && en && full;

  assign pop            = access && !is_write && (reg_sel == REG_DATA) && !empty;
  assign udf_set        = access && !is_write && (reg_sel == REG_DATA) && empty;
  assign ctrl_wr        = access && is_write && (reg_sel == REG_CTRL);
  assign status_clr_ovf = access && is_write && (reg_sel == REG_STATUS)
                          && iomem_wstrb[0] && iomem_wdata[2];
  assign status_clr_udf = access && is_write && (reg_sel == REG_STATUS)
                          && iomem_wstrb[0] && iomem_wdata[3];

  // count is one bit wider than the pointers; at DEPTH=256 the 8-bit field clips.
  always_comb begin
    count_field = 8'(count);
    if (32'(count) > 32'd255) count_field = 8'hFF;
  end

  always_comb begin
    rdata_next = '0;
    unique case (reg_sel)
      REG_CTRL:   rdata_next = {16'h0, thresh, 6'b0, irq_en, en};
      REG_STATUS: rdata_next = {16'h0, count_field, 4'b0, udf, ovf, full, empty};
      REG_DATA:   rdata_next = empty ? '0 : mem[rd_ptr];
      REG_RSVD:   rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      en          <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      iomem_ready <= access;
      iomem_rdata <= (access && !is_write) ? rdata_next : '0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (ctrl_wr && iomem_wstrb[0]) en <= iomem_wdata[0];

      // A new event in the same cycle as a W1C clear wins.
      if (status_clr_ovf) ovf <= 1'b0;
      if (ovf_set)        ovf <= 1'b1;
      if (status_clr_udf) udf <= 1'b0;
      if (udf_set)        udf <= 1'b1;
    end
  end

`ifdef IOMEM_PIXEL_FIFO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      thresh <= '0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr && iomem_wstrb[0]) irq_en <= iomem_wdata[1];
      if (ctrl_wr && iomem_wstrb[1]) thresh <= iomem_wdata[15:8];
      irq <= irq_en && (thresh != '0) && (32'(count) >= 32'(thresh));
    end
  end
`else
  assign irq_en = 1'b0;
  assign thresh = '0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_pixel_fifo.sv
module tb_iomem_pixel_fifo;

  localparam int DEPTH = 16;
`ifdef IOMEM_PIXEL_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] pix_data = '0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit [31:0] q[$];
  bit        m_en, m_irq_en, m_ovf, m_udf, m_ready, m_irq;
  bit [7:0]  m_thr;
  bit [31:0] m_rdata;

  iomem_pixel_fifo #(.BASE_ADDR(32'h0300_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_udf = 0;
    m_ready = 0; m_irq = 0; m_thr = 0; m_rdata = 0;
  endtask

  // Advance one clock; model predicts the edge from the rules, then outputs are compared.
  task automatic cycle();
    int n;
    bit hit, acc, wr, accept, ovf_ev, nirq;
    bit [31:0] rd;
    bit [7:0]  cnt8;
    n = q.size();
    if (reset) begin
      model_reset();
    end else begin
      hit    = iomem_valid && (iomem_addr[31:4] == 28'h030_0000);
      acc    = hit && !m_ready;
      wr     = (iomem_wstrb != 0);
      accept = pix_valid && m_en && (n < DEPTH);
      ovf_ev = pix_valid && m_en && (n == DEPTH);
      nirq   = IRQ_ON && m_irq_en && (m_thr != 0) && (n >= m_thr);
      cnt8   = (n > 255) ? 8'hFF : 8'(n);
      rd     = 0;
      if (acc) begin
        case (iomem_addr[3:2])
          2'd0: if (wr) begin
                  if (iomem_wstrb[0]) begin
                    m_en = iomem_wdata[0];
                    if (IRQ_ON) m_irq_en = iomem_wdata[1];
                  end
                  if (iomem_wstrb[1] && IRQ_ON) m_thr = iomem_wdata[15:8];
                end else rd = {16'h0, m_thr, 6'b0, m_irq_en, m_en};
          2'd1: if (wr) begin
                  if (iomem_wstrb[0] && iomem_wdata[2]) m_ovf = 0;
                  if (iomem_wstrb[0] && iomem_wdata[3]) m_udf = 0;
                end else rd = {16'h0, cnt8, 4'b0, m_udf, m_ovf, n == DEPTH, n == 0};
          2'd2: if (!wr) begin
                  if (n == 0) m_udf = 1;
                  else rd = q.pop_front();
                end
          default: ;
        endcase
      end
      if (ovf_ev) m_ovf = 1;
      if (accept) q.push_back(pix_data);
      m_ready = acc;
      m_rdata = (acc && !wr) ? rd : 0;
      m_irq   = nirq;
    end
    @(posedge clk); #1;
    check("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
    check("rdata", iomem_rdata, m_rdata);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("pix_ready", {31'b0, pix_ready}, {31'b0, m_en && (q.size() < DEPTH)});
  endtask

  // One bus transaction; returns the data seen on the ready cycle.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    iomem_valid = 1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wdata;
    rdata = 'x;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (m_ready) begin
        rdata = iomem_rdata;
        break;
      end
    end
    iomem_valid = 0; iomem_wstrb = 0;
  endtask

  task automatic push_word(input logic [31:0] d);
    pix_valid = 1; pix_data = d;
    cycle();
    pix_valid = 0;
  endtask

  logic [31:0] r;
  localparam logic [31:0] B = 32'h0300_0000;

  initial begin
    model_reset();
    cycle(); cycle();
    reset = 0;

    bus(B + 4, 4'h0, 0, r);  check("status_after_reset", r, 32'h1);
    bus(B + 0, 4'h0, 0, r);  check("ctrl_after_reset", r, 32'h0);

    bus(B + 0, 4'hF, 32'h0000_0303, r);
    bus(B + 0, 4'h0, 0, r);  check("ctrl_readback", r, IRQ_ON ? 32'h303 : 32'h1);
    for (int i = 0; i < 3; i++) push_word(32'hA0 + i);
    cycle();
    check("irq_at_thresh", {31'b0, irq}, {31'b0, IRQ_ON});
    bus(B + 4, 4'h0, 0, r);  check("status_3", r, 32'h0000_0300);
    bus(B + 8, 4'h0, 0, r);  check("pop_a0", r, 32'hA0);
    cycle();
    check("irq_after_pop", {31'b0, irq}, 32'h0);
    bus(B + 8, 4'h0, 0, r);  check("pop_a1", r, 32'hA1);
    bus(B + 8, 4'h0, 0, r);  check("pop_a2", r, 32'hA2);

    // Fill past capacity
    bus(B + 0, 4'hF, 32'h1, r);
    for (int i = 0; i < 17; i++) begin
      push_word(32'hB00 + i);
      if (i == 15) check("pix_ready_full", {31'b0, pix_ready}, 32'h0);
    end
    bus(B + 4, 4'h0, 0, r);  check("status_full_ovf", r, 32'h0000_1006);
    bus(B + 4, 4'hF, 32'h4, r);
    bus(B + 4, 4'h0, 0, r);  check("status_ovf_clr", r, 32'h0000_1002);

    // Pop from full while the stream is offering a word
    pix_valid = 1; pix_data = 32'hC0DE_0001;
    bus(B + 8, 4'h0, 0, r);  check("pop_full_head", r, 32'hB00);
    check("pix_ready_after_pop", {31'b0, pix_ready}, 32'h1);
    cycle();
    check("refilled", {31'b0, pix_ready}, 32'h0);
    pix_valid = 0;
    bus(B + 4, 4'h0, 0, r);  check("status_refill", r, 32'h0000_1006);
    bus(B + 4, 4'h1, 32'hC, r);

    // Drain, then underflow
    for (int i = 0; i < DEPTH; i++) bus(B + 8, 4'h0, 0, r);
    check("last_word", r, 32'hC0DE_0001);
    bus(B + 8, 4'h0, 0, r);  check("empty_read", r, 32'h0);
    bus(B + 4, 4'h0, 0, r);  check("status_udf", r, 32'h0000_0009);
    bus(B + 4, 4'h1, 32'h8, r);

    // Address outside the window: no completion, no side effects
    iomem_valid = 1; iomem_addr = B + 32'h10; iomem_wstrb = 4'hF; iomem_wdata = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("miss_no_ready", {31'b0, iomem_ready}, 32'h0);
    end
    iomem_valid = 0; iomem_wstrb = 0;
    bus(B + 0, 4'h0, 0, r);  check("ctrl_after_miss", r, 32'h1);
    bus(B + 4, 4'h0, 0, r);  check("status_after_miss", r, 32'h1);
    bus(B + 12, 4'hF, '1, r);
    bus(B + 12, 4'h0, 0, r); check("reserved_zero", r, 32'h0);

    // Randomised mixed traffic
    bus(B + 0, 4'hF, 32'h0000_0803, r);
    for (int i = 0; i < 40; i++) begin
      pix_data = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        pix_valid = $urandom_range(0, 1);
        bus(B + 8, 4'h0, 0, r);
      end else begin
        pix_valid = 1;
        cycle();
      end
      pix_valid = 0;
    end

    // Reset in the ready cycle of a DATA read with five words stored
    while (q.size() > 0) bus(B + 8, 4'h0, 0, r);
    bus(B + 0, 4'hF, 32'h0000_0303, r);
    for (int i = 0; i < 5; i++) push_word(32'hD0 + i);
    cycle();
    check("irq_before_reset", {31'b0, irq}, {31'b0, IRQ_ON});
    iomem_valid = 1; iomem_addr = B + 8; iomem_wstrb = 0;
    cycle();
    check("ready_cycle1", {31'b0, iomem_ready}, 32'h1);
    reset = 1; #1;
    check("rst_ready", {31'b0, iomem_ready}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    check("rst_pix_ready", {31'b0, pix_ready}, 32'h0);
    iomem_valid = 0;
    cycle();
    reset = 0;
    bus(B + 4, 4'h0, 0, r);  check("status_post_reset", r, 32'h1);
    bus(B + 0, 4'h0, 0, r);  check("ctrl_post_reset", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
